// File: rtl/wb_pkg.sv
// Shared Wishbone definitions: default widths, arbiter state encoding and a
// loop-based round-robin helper for arbiters that prefer a function to a module.
package wb_pkg;

    localparam int WB_DW = 32;
    localparam int WB_AW = 32;
    localparam int WB_TW = 3;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_OWNED = 1'b1
    } arb_state_e;

    // Index of the first requester after 'last', wrapping over n (n <= 8) ports;
    // returns 'last' unchanged when nobody requests.
    function automatic logic [2:0] rr_pick(input logic [7:0] req,
                                           input logic [2:0] last,
                                           input int         n);
        logic [2:0] win;
        win = last;
        for (int k = n; k >= 1; k--) begin
            int idx;
            idx = (int'(last) + k) % n;
            if (req[idx]) win = idx[2:0];
        end
        return win;
    endfunction

endpackage

// File: rtl/wb_rr_arbiter_if.sv
// Bus bundle between N Wishbone masters, the round-robin arbiter and one slave.
// Modports: arb (the arbiter), master (the requesting side), slave (the target).
interface wb_rr_arbiter_if
    import wb_pkg::*;
#(
    parameter int NM = 2,
    parameter int DW = WB_DW,
    parameter int AW = WB_AW,
    parameter int TW = WB_TW
);
    logic [NM*TW-1:0]     m_tag;
    logic [NM*AW-1:0]     m_adr;
    logic [NM-1:0]        m_stb;
    logic [NM-1:0]        m_cyc;
    logic [NM*DW-1:0]     m_dwr;
    logic [NM*DW/8-1:0]   m_sel;
    logic [NM-1:0]        m_we;
    logic [NM-1:0]        m_lock;
    logic [DW-1:0]        m_drd;
    logic [NM-1:0]        m_ack;
    logic [NM-1:0]        m_err;

    logic [TW-1:0]        s_tag;
    logic [AW-1:0]        s_adr;
    logic                 s_stb;
    logic                 s_cyc;
    logic [DW-1:0]        s_dwr;
    logic [DW/8-1:0]      s_sel;
    logic                 s_we;
    logic                 s_lock;
    logic [DW-1:0]        s_drd;
    logic                 s_ack;
    logic                 s_err;

    logic [NM-1:0]        gnt;

    modport arb (
        input  m_tag, m_adr, m_stb, m_cyc, m_dwr, m_sel, m_we, m_lock,
        output m_drd, m_ack, m_err,
        output s_tag, s_adr, s_stb, s_cyc, s_dwr, s_sel, s_we, s_lock,
        input  s_drd, s_ack, s_err,
        output gnt
    );

    modport master (
        output m_tag, m_adr, m_stb, m_cyc, m_dwr, m_sel, m_we, m_lock,
        input  m_drd, m_ack, m_err, gnt
    );

    modport slave (
        input  s_tag, s_adr, s_stb, s_cyc, s_dwr, s_sel, s_we, s_lock,
        output s_drd, s_ack, s_err
    );

endinterface

// File: rtl/wb_rr_pick.sv
// Combinational round-robin picker: rotate requests to start after 'last',
// priority-encode the lowest, rotate back; one-hot grant plus its index.
module wb_rr_pick #(
    parameter int N  = 2,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          any
);
    logic [IW-1:0] start;
    logic [N-1:0]  rot;
    logic [IW-1:0] off;

    assign start = (int'(last) >= N - 1) ? '0 : last + IW'(1);

    always_comb begin
        // NOTE: every combinational output gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        rot = '0;
        for (int i = 0; i < N; i++) rot[i] = req[(int'(start) + i) % N];
    end

    always_comb begin
        off = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rot[i]) off = IW'(i);
        end
    end

    assign any = |req;
    assign idx = IW'((int'(start) + int'(off)) % N);
    assign gnt = any ? (N'(1) << idx) : '0;

endmodule

// File: rtl/wb_rr_arbiter.sv
// N-master to 1-slave Wishbone B4 round-robin arbiter with registered grant and lock.
// Optional bus timeout enabled by defining WB_ARB_TIMEOUT_EN.
module wb_rr_arbiter
    import wb_pkg::*;
#(
    parameter int NM      = 2,
    parameter int DW      = WB_DW,
    parameter int AW      = WB_AW,
    parameter int TW      = WB_TW,
    parameter int TIMEOUT = 255
) (
    input logic          clk,
    input logic          rst,
    wb_rr_arbiter_if.arb bus
);
    localparam int IW = (NM > 1) ? $clog2(NM) : 1;
    localparam int SW = DW / 8;

    if (NM < 2 || NM > 8 || TIMEOUT < 1) begin : g_bad_cfg
        $error("wb_rr_arbiter: NM must be 2..8 and TIMEOUT at least 1");
    end

    arb_state_e    state, state_d;
    logic [NM-1:0] gnt_q, gnt_d;
    logic [IW-1:0] last_q, last_d;
    logic [NM-1:0] pick_gnt;
    logic [IW-1:0] pick_idx;
    logic          pick_any;
    logic          owned;
    logic          tmo_hit;
    int            gi;

    wb_rr_pick #(.N(NM), .IW(IW)) u_pick (
        .req  (bus.m_cyc),
        .last (last_q),
        .gnt  (pick_gnt),
        .idx  (pick_idx),
        .any  (pick_any)
    );

    // last_q doubles as the index of the current owner while OWNED.
    assign gi    = int'(last_q);
    assign owned = (state == ARB_OWNED);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= ARB_IDLE;
            gnt_q  <= '0;
            last_q <= IW'(NM - 1);
        end else begin
            // NOTE: non-blocking so every register here samples pre-edge values.
            state  <= state_d;
            gnt_q  <= gnt_d;
            last_q <= last_d;
        end
    end

    always_comb begin
        state_d = state;
        gnt_d   = gnt_q;
        last_d  = last_q;
        case (state)
            ARB_IDLE: begin
                if (pick_any) begin
                    state_d = ARB_OWNED;
                    gnt_d   = pick_gnt;
                    last_d  = pick_idx;
                end
            end
            ARB_OWNED: begin
                // A held lock keeps ownership even with cyc low.
                if (!bus.m_cyc[gi] && !bus.m_lock[gi]) begin
                    state_d = ARB_IDLE;
                    gnt_d   = '0;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

`ifdef WB_ARB_TIMEOUT_EN
    localparam int TCW = $clog2(TIMEOUT + 1);

    logic [TCW-1:0] tmo_cnt;
    logic           stalled;

    assign stalled = owned && bus.m_stb[gi] && !bus.s_ack && !bus.s_err;
    assign tmo_hit = stalled && (tmo_cnt == TCW'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                    tmo_cnt <= '0;
        else if (!stalled || tmo_hit) tmo_cnt <= '0;
        else                        tmo_cnt <= tmo_cnt + TCW'(1);
    end
`else
    assign tmo_hit = 1'b0;
`endif

    always_comb begin
        bus.s_tag  = '0;
        bus.s_adr  = '0;
        bus.s_stb  = 1'b0;
        bus.s_cyc  = 1'b0;
        bus.s_dwr  = '0;
        bus.s_sel  = '0;
        bus.s_we   = 1'b0;
        bus.s_lock = 1'b0;
        bus.m_ack  = '0;
        bus.m_err  = '0;
        if (owned) begin
            bus.s_tag     = bus.m_tag[gi*TW +: TW];
            bus.s_adr     = bus.m_adr[gi*AW +: AW];
            bus.s_stb     = bus.m_stb[gi] & ~tmo_hit;
            bus.s_cyc     = bus.m_cyc[gi];
            bus.s_dwr     = bus.m_dwr[gi*DW +: DW];
            bus.s_sel     = bus.m_sel[gi*SW +: SW];
            bus.s_we      = bus.m_we[gi];
            bus.s_lock    = bus.m_lock[gi];
            bus.m_ack[gi] = bus.s_ack;
            bus.m_err[gi] = bus.s_err | tmo_hit;
        end
    end

    assign bus.m_drd = bus.s_drd;
    assign bus.gnt   = gnt_q;

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Self-checking bench for wb_rr_arbiter: directed scenarios then random traffic,
// compared against an ownership-level reference model.
module tb_wb_rr_arbiter;
    localparam int NM      = 3;
    localparam int DW      = 32;
    localparam int AW      = 32;
    localparam int TW      = 3;
    localparam int SW      = DW / 8;
    localparam int TIMEOUT = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    wb_rr_arbiter_if #(.NM(NM), .DW(DW), .AW(AW), .TW(TW)) bus ();

    wb_rr_arbiter #(.NM(NM), .DW(DW), .AW(AW), .TW(TW), .TIMEOUT(TIMEOUT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic          cyc  [NM];
    logic          stb  [NM];
    logic          we   [NM];
    logic          lock [NM];
    logic [AW-1:0] adr  [NM];
    logic [DW-1:0] dwr  [NM];
    logic [SW-1:0] sel  [NM];
    logic [TW-1:0] tag  [NM];
    logic [DW-1:0] sdrd;
    logic          sack;
    logic          serr;

    // Reference: who owns the bus (-1 = nobody), who was granted last,
    // and how many consecutive stalled strobes the owner has accumulated.
    int owner, last_idx, stall_run;
    int checks = 0;
    int errors = 0;

    task automatic check(input string tag_s, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag_s, obs, exp);
        end
    endtask

    task automatic idle_all();
        for (int i = 0; i < NM; i++) begin
            cyc[i] = 1'b0; stb[i] = 1'b0; we[i] = 1'b0; lock[i] = 1'b0;
            adr[i] = '0;   dwr[i] = '0;   sel[i] = '0;  tag[i] = '0;
        end
        sdrd = '0; sack = 1'b0; serr = 1'b0;
    endtask

    task automatic apply();
        for (int i = 0; i < NM; i++) begin
            bus.m_cyc[i]              = cyc[i];
            bus.m_stb[i]              = stb[i];
            bus.m_we[i]               = we[i];
            bus.m_lock[i]             = lock[i];
            bus.m_adr[i*AW +: AW]     = adr[i];
            bus.m_dwr[i*DW +: DW]     = dwr[i];
            bus.m_sel[i*SW +: SW]     = sel[i];
            bus.m_tag[i*TW +: TW]     = tag[i];
        end
        bus.s_drd = sdrd;
        bus.s_ack = sack;
        bus.s_err = serr;
    endtask

    function automatic void model_reset();
        owner     = -1;
        last_idx  = NM - 1;
        stall_run = 0;
    endfunction

    function automatic int pick();
        for (int k = 1; k <= NM; k++) begin
            int idx;
            idx = (last_idx + k) % NM;
            if (cyc[idx]) return idx;
        end
        return -1;
    endfunction

    function automatic bit model_stalled();
        return owner >= 0 && stb[owner] && !sack && !serr;
    endfunction

    function automatic bit model_hit();
`ifdef WB_ARB_TIMEOUT_EN
        return model_stalled() && (stall_run + 1 == TIMEOUT);
`else
        return 1'b0;
`endif
    endfunction

    function automatic void model_step();
        bit h;
        h = model_hit();
        if (owner < 0) begin
            owner = pick();
            if (owner >= 0) last_idx = owner;
            stall_run = 0;
        end else begin
            stall_run = (model_stalled() && !h) ? stall_run + 1 : 0;
            if (!cyc[owner] && !lock[owner]) owner = -1;
        end
    endfunction

    task automatic check_all();
        logic [NM-1:0] e_gnt, e_ack, e_err;
        logic [AW-1:0] e_adr;
        logic [DW-1:0] e_dwr;
        logic [SW-1:0] e_sel;
        logic [TW-1:0] e_tag;
        logic          e_cyc, e_stb, e_we, e_lock, h;
        e_gnt = '0; e_ack = '0; e_err = '0;
        e_adr = '0; e_dwr = '0; e_sel = '0; e_tag = '0;
        e_cyc = 1'b0; e_stb = 1'b0; e_we = 1'b0; e_lock = 1'b0;
        h = model_hit();
        if (owner >= 0) begin
            e_gnt[owner] = 1'b1;
            e_cyc  = cyc[owner];
            e_stb  = stb[owner] & ~h;
            e_we   = we[owner];
            e_lock = lock[owner];
            e_adr  = adr[owner];
            e_dwr  = dwr[owner];
            e_sel  = sel[owner];
            e_tag  = tag[owner];
            e_ack[owner] = sack;
            e_err[owner] = serr | h;
        end
        check("gnt",    64'(bus.gnt),    64'(e_gnt));
        check("s_cyc",  64'(bus.s_cyc),  64'(e_cyc));
        check("s_stb",  64'(bus.s_stb),  64'(e_stb));
        check("s_we",   64'(bus.s_we),   64'(e_we));
        check("s_lock", 64'(bus.s_lock), 64'(e_lock));
        check("s_adr",  64'(bus.s_adr),  64'(e_adr));
        check("s_dwr",  64'(bus.s_dwr),  64'(e_dwr));
        check("s_sel",  64'(bus.s_sel),  64'(e_sel));
        check("s_tag",  64'(bus.s_tag),  64'(e_tag));
        check("m_ack",  64'(bus.m_ack),  64'(e_ack));
        check("m_err",  64'(bus.m_err),  64'(e_err));
        check("m_drd",  64'(bus.m_drd),  64'(sdrd));
    endtask

    // One clock: drive, check mid-cycle, advance model with the edge.
    task automatic cycle();
        apply();
        @(negedge clk);
        check_all();
        @(posedge clk);
        model_step();
        #1;
    endtask

    // Asynchronous reset between edges; outputs must drop without a clock.
    task automatic do_reset();
        apply();
        #2 rst = 1'b1;
        #1;
        check("rst_gnt",   64'(bus.gnt),   64'd0);
        check("rst_s_cyc", 64'(bus.s_cyc), 64'd0);
        check("rst_s_stb", 64'(bus.s_stb), 64'd0);
        check("rst_m_ack", 64'(bus.m_ack), 64'd0);
        check("rst_m_err", 64'(bus.m_err), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        @(posedge clk);
        model_step();
        #1;
    endtask

    initial begin
        logic exp_err;

        // Power-on reset.
        idle_all();
        apply();
        repeat (2) @(negedge clk);
        check("por_gnt",   64'(bus.gnt),   64'd0);
        check("por_s_cyc", 64'(bus.s_cyc), 64'd0);
        check("por_m_ack", 64'(bus.m_ack), 64'd0);
        rst = 1'b0;
        model_reset();
        @(posedge clk);
        model_step();
        #1;

        // Single master: grant one clock after cyc rises, ack routed to it only.
        cyc[0] = 1'b1; stb[0] = 1'b1; adr[0] = 32'h0000_1000;
        cycle();
        check("single_gnt", 64'(bus.gnt),   64'(3'b001));
        check("single_adr", 64'(bus.s_adr), 64'h1000);
        sack = 1'b1;
        apply();
        #1;
        check("single_ack", 64'(bus.m_ack), 64'(3'b001));
        cycle();
        sack = 1'b0;
        cyc[0] = 1'b0; stb[0] = 1'b0;
        cycle();
        cycle();

        // Contention from reset: master 0 first, then strict alternation.
        cyc[0] = 1'b1; stb[0] = 1'b1; cyc[1] = 1'b1; stb[1] = 1'b1;
        do_reset();
        for (int k = 0; k < 4; k++) begin
            check("rr_order", 64'(bus.gnt), 64'(3'b001 << (k % 2)));
            cyc[k % 2] = 1'b0;
            cycle();
            check("rr_dead_gnt",  64'(bus.gnt),   64'd0);
            check("rr_dead_scyc", 64'(bus.s_cyc), 64'd0);
            cyc[k % 2] = 1'b1;
            cycle();
        end

        // Lock: master 1 keeps the grant across cyc pulses while master 0 waits.
        idle_all();
        cyc[1] = 1'b1; stb[1] = 1'b1; lock[1] = 1'b1;
        do_reset();
        check("lock_gnt0", 64'(bus.gnt), 64'(3'b010));
        cyc[0] = 1'b1; stb[0] = 1'b1;
        cyc[1] = 1'b0;
        cycle();
        check("lock_gnt1", 64'(bus.gnt),   64'(3'b010));
        check("lock_scyc", 64'(bus.s_cyc), 64'd0);
        cyc[1] = 1'b1;
        cycle();
        check("lock_gnt2", 64'(bus.gnt), 64'(3'b010));
        cyc[1] = 1'b0;
        cycle();
        check("lock_gnt3", 64'(bus.gnt), 64'(3'b010));
        lock[1] = 1'b0;
        cycle();
        check("lock_rel",  64'(bus.gnt), 64'd0);
        cycle();
        check("lock_m0",   64'(bus.gnt), 64'(3'b001));

        // Read data and error routed to master 1 only.
        cyc[0] = 1'b0; stb[0] = 1'b0; cyc[1] = 1'b1; stb[1] = 1'b1;
        cycle();
        cycle();
        sdrd = 32'hDEAD_BEEF; serr = 1'b1;
        apply();
        #1;
        check("err_m_err", 64'(bus.m_err), 64'(3'b010));
        check("err_m_drd", 64'(bus.m_drd), 64'hDEAD_BEEF);
        check("err_m_ack", 64'(bus.m_ack), 64'd0);
        cycle();
        serr = 1'b0;

        // Asynchronous reset mid-transfer; master 0 wins first afterwards.
        cyc[1] = 1'b0; stb[1] = 1'b0;
        cycle();
        cyc[0] = 1'b1; stb[0] = 1'b1;
        cycle();
        sack = 1'b1;
        apply();
        #1;
        check("pre_rst_ack", 64'(bus.m_ack), 64'(3'b001));
        cyc[1] = 1'b1; stb[1] = 1'b1;
        do_reset();
        check("post_rst_gnt", 64'(bus.gnt), 64'(3'b001));
        sack = 1'b0;
        cycle();

        // Hung slave: error pulse at every TIMEOUT-th stalled cycle, or never.
        idle_all();
        cyc[0] = 1'b1; stb[0] = 1'b1;
        do_reset();
        for (int k = 1; k <= 20; k++) begin
            exp_err = 1'b0;
`ifdef WB_ARB_TIMEOUT_EN
            exp_err = (k % TIMEOUT == 0);
`endif
            check("tmo_err", 64'(bus.m_err), 64'({2'b00, exp_err}));
            check("tmo_stb", 64'(bus.s_stb), 64'(!exp_err));
            cycle();
        end

        // Random traffic against the reference model.
        idle_all();
        cyc[0] = 1'b0;
        cycle();
        for (int n = 0; n < 600; n++) begin
            for (int i = 0; i < NM; i++) begin
                if ($urandom_range(0, 9) < 3) begin
                    cyc[i]  = ($urandom_range(0, 9) < 7);
                    stb[i]  = 1'($urandom_range(0, 1));
                    lock[i] = ($urandom_range(0, 9) < 2);
                    we[i]   = 1'($urandom_range(0, 1));
                    adr[i]  = $urandom;
                    dwr[i]  = $urandom;
                    sel[i]  = SW'($urandom);
                    tag[i]  = TW'($urandom);
                end
            end
            sack = ($urandom_range(0, 9) < 3);
            serr = !sack && ($urandom_range(0, 9) < 1);
            sdrd = $urandom;
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_rr_arbiter.md
Name: wb_rr_arbiter

Overview:
- N-master to 1-slave Wishbone B4 arbiter (no stall/rty), placed between the NEORV32 bus master, other bus masters (e.g. DMA/HDMI fetch) and the shared peripheral/memory slave.
- Grants are round-robin and held for a full cycle. Master `lock` extends a grant across back-to-back cycles.
- Signal set per port matches the team Wishbone interface: tag, adr, stb, cyc, dwr, drd, sel, we, lock, ack, err.

Parameters:
- NM, 2, number of masters (2..8)
- DW, 32, data width
- AW, 32, address width
- TW, 3, tag width
- TIMEOUT, 255, bus-timeout cycle limit (used only with the optional feature)

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- m_tag  in  NM*TW  master tags, master i at slice [i*TW +: TW]
- m_adr  in  NM*AW  master addresses
- m_stb  in  NM  master strobes
- m_cyc  in  NM  master cycle requests
- m_dwr  in  NM*DW  master write data
- m_sel  in  NM*DW/8  master byte selects
- m_we  in  NM  master write enables
- m_lock  in  NM  master lock requests
- m_drd  out  DW  read data, broadcast to all masters
- m_ack  out  NM  per-master ack
- m_err  out  NM  per-master err
- s_tag, s_adr, s_stb, s_cyc, s_dwr, s_sel, s_we, s_lock  out  TW/AW/1/1/DW/DW/8/1/1  slave side
- s_drd  in  DW  slave read data
- s_ack  in  1  slave ack
- s_err  in  1  slave err
- gnt  out  NM  one-hot current grant (status/debug)

Behaviour:
- Reset is asynchronous and active-high. While rst is high:
  - state = IDLE
  - gnt = 0
  - last_gnt = NM-1, so master 0 wins first
  - timeout counter = 0
  - all s_* outputs, m_ack and m_err are 0
- Two states, IDLE and OWNED. The grant is registered.
- IDLE:
  - If any m_cyc is high, pick the first requester at or above index (last_gnt+1) mod NM, wrapping.
  - Register the one-hot gnt and last_gnt, then go to OWNED.
  - Grant latency is 1 clock from the rising edge of m_cyc.
  - s_cyc = s_stb = 0 in this state.
- OWNED:
  - All s_* outputs are a combinational mux of the granted master's signals.
  - m_ack[g] = s_ack and m_err[g] = s_err for the granted master g only; all other masters see 0.
  - m_drd = s_drd, unmuxed.
- Release:
  - When the granted master's m_cyc goes low and its m_lock is also low, return to IDLE on the next edge.
  - This leaves exactly 1 dead cycle (s_cyc = 0) between grants.
- Lock:
  - If the granted master drops m_cyc while holding m_lock high, the grant is retained; s_cyc follows m_cyc.
  - The other masters stay blocked until the lock drops.
- Simultaneous requests:
  - Round-robin order only, no fixed priority after reset.
  - A master that has just released cannot win again while another master is waiting.
- Requests from non-granted masters are held pending with no side effect. The arbiter has no queue; the master keeps m_cyc high until granted.
- Mid-cycle reset: all outputs drop to 0 immediately (asynchronous). The slave sees s_cyc fall, and in-flight transfers are abandoned.
- s_ack/s_err arriving in IDLE (a protocol violation) are ignored.

Optional Feature:
- Macro: WB_ARB_TIMEOUT_EN.
- Defined:
  - An 8..16-bit counter (width clog2(TIMEOUT+1)) increments each OWNED cycle with s_stb=1 and s_ack=s_err=0.
  - The counter clears on ack, on err, or when stb is low.
  - When the count reaches TIMEOUT, m_err[g] is pulsed for 1 cycle and s_stb is forced 0 in that cycle; the counter then clears.
  - The grant is released as normal when the master drops cyc.
- Undefined: no counter is present, and a hung slave stalls the bus indefinitely.

Decomposition:
- Package wb_pkg holds:
  - default width constants (WB_DW, WB_AW, WB_TW)
  - the arbiter state enum (ARB_IDLE, ARB_OWNED)
  - a round-robin helper function rr_pick(req, last)
- One sub-module, wb_rr_pick: combinational rotate/priority-encode/unrotate producing a one-hot grant. It is reusable by other arbiters.
- The FSM, muxing and timeout live in the top level.

Test Plan:
- Single master: m_cyc[0]=m_stb[0]=1, adr=0x1000 → gnt=01 after 1 clk; s_adr=0x1000; slave ack → m_ack[0]=1, m_ack[1]=0.
- Contention: m_cyc=11 on the same cycle after reset → master 0 granted first. Master 0 releases → 1 dead cycle → master 1 granted; order thereafter alternates 0,1,0,1.
- Lock: master 1 holds m_lock=1 across two cyc pulses while master 0 requests → master 0 is not granted until master 1 deasserts both lock and cyc.
- Read data/err routing: slave returns s_drd=0xDEADBEEF with s_err=1 on master 1's cycle → m_err=10, m_drd=0xDEADBEEF, m_ack=00.
- Async reset mid-transfer: assert rst between clock edges while gnt=01 → s_cyc, gnt, m_ack drop the same instant; after release, master 0 wins first again.
- Timeout (WB_ARB_TIMEOUT_EN, TIMEOUT=8): slave never acks → m_err[g] pulses exactly at the 8th stalled cycle, s_stb=0 in that cycle; without the macro, no err is ever raised.
